// File: rtl/stdout_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : stdout_uart_tx
// Brief    : FIFO-buffered UART transmitter for the CPU stdout byte strobe.
//            Define VERIFUCK_UART_PARITY_EN to insert a parity bit.
// Revision : 1.0 - initial parametrised release
// ============================================================================

module stdout_uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int BAUD_DIV   = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] stdout,
    input  logic                 stdout_en,
    output logic                 stdout_full,
    output logic                 uart_tx_pin,
    output logic                 busy,
    output logic                 overflow
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(BAUD_DIV - 1);
    localparam logic [c_CW-1:0] c_FULL_CNT  = c_CW'(FIFO_DEPTH);
    localparam logic [3:0]      c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      c_STOP_LAST = 4'(STOP_BITS - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_STOP   = 3'd4;
`ifdef VERIFUCK_UART_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic       c_PAR_INV = (PARITY_ODD != 0);
`endif

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]      r_wr_ptr;
    logic [c_PW-1:0]      r_rd_ptr;
    logic [c_CW-1:0]      r_count;
    logic                 r_full;
    logic                 r_overflow;
    logic                 r_busy;

    logic [2:0]           r_state;
    logic [c_BW-1:0]      r_baud_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
`ifdef VERIFUCK_UART_PARITY_EN
    logic                 r_parity;
`endif

    logic [2:0]           w_state_next;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_baud_tc;
    logic                 w_fifo_nonempty;
    logic [c_CW-1:0]      w_count_next;
    logic                 w_pin;

    assign w_push          = stdout_en & ~r_full;
    assign w_baud_tc       = (r_baud_cnt == c_BAUD_LAST);
    assign w_fifo_nonempty = (r_count != '0);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Storage is not reset; occupancy is tracked solely by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= stdout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_FULL_CNT);
            if (stdout_en && r_full) begin
                r_overflow <= 1'b1;
            end
            r_busy <= (w_state_next != c_IDLE) || (w_count_next != '0);
        end
    end

    // FSM state register and datapath counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
`ifdef VERIFUCK_UART_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (r_state == c_IDLE || w_baud_tc) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
            if (r_state == c_IDLE || (w_baud_tc && w_state_next != r_state)) begin
                r_bit_cnt <= '0;
            end else if (w_baud_tc) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
            end else if (r_state == c_DATA && w_baud_tc) begin
                r_shift <= r_shift >> 1;
            end
`ifdef VERIFUCK_UART_PARITY_EN
            if (w_pop) begin
                r_parity <= (^r_mem[r_rd_ptr]) ^ c_PAR_INV;
            end
`endif
        end
    end

    // Next-state logic; a pop always coincides with entering START
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_fifo_nonempty) begin
                    w_pop        = 1'b1;
                    w_state_next = c_START;
                end
            end
            c_START: begin
                if (w_baud_tc) begin
                    w_state_next = c_DATA;
                end
            end
            c_DATA: begin
                if (w_baud_tc && r_bit_cnt == c_DATA_LAST) begin
`ifdef VERIFUCK_UART_PARITY_EN
                    w_state_next = c_PARITY;
`else
                    w_state_next = c_STOP;
`endif
                end
            end
`ifdef VERIFUCK_UART_PARITY_EN
            c_PARITY: begin
                if (w_baud_tc) begin
                    w_state_next = c_STOP;
                end
            end
`endif
            c_STOP: begin
                if (w_baud_tc && r_bit_cnt == c_STOP_LAST) begin
                    if (w_fifo_nonempty) begin
                        w_pop        = 1'b1;
                        w_state_next = c_START;
                    end else begin
                        w_state_next = c_IDLE;
                    end
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_pin = 1'b1;
        case (r_state)
            c_START: w_pin = 1'b0;
            c_DATA:  w_pin = r_shift[0];
`ifdef VERIFUCK_UART_PARITY_EN
            c_PARITY: w_pin = r_parity;
`endif
            default: w_pin = 1'b1;
        endcase
    end

    assign uart_tx_pin = w_pin;
    assign stdout_full = r_full;
    assign busy        = r_busy;
    assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_stdout_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_stdout_uart_tx
// Brief    : Self-checking bench for stdout_uart_tx (three parameter sets).
// Revision : 1.0
// ============================================================================

module tb_stdout_uart_tx;

`ifdef VERIFUCK_UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int CFG_D[3] = '{8, 8, 7};
    localparam int CFG_S[3] = '{1, 1, 2};
    localparam int CFG_B[3] = '{3, 8, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic       en0, en1, en2;
    logic       full0, pin0, busy0, ovf0;
    logic       full1, pin1, busy1, ovf1;
    logic       full2, pin2, busy2, ovf2;

    stdout_uart_tx u_dut0 (
        .clk(clk), .rst(rst), .stdout(d0), .stdout_en(en0),
        .stdout_full(full0), .uart_tx_pin(pin0), .busy(busy0), .overflow(ovf0)
    );

    stdout_uart_tx #(.FIFO_DEPTH(4), .BAUD_DIV(8)) u_dut1 (
        .clk(clk), .rst(rst), .stdout(d1), .stdout_en(en1),
        .stdout_full(full1), .uart_tx_pin(pin1), .busy(busy1), .overflow(ovf1)
    );

    stdout_uart_tx #(.DATA_BITS(7), .STOP_BITS(2), .BAUD_DIV(1)) u_dut2 (
        .clk(clk), .rst(rst), .stdout(d2), .stdout_en(en2),
        .stdout_full(full2), .uart_tx_pin(pin2), .busy(busy2), .overflow(ovf2)
    );

    typedef struct {
        int          id;
        logic [7:0]  din;
        logic [11:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] q0[$], q1[$], q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_pin(input int id);
        case (id)
            0: return pin0;
            1: return pin1;
            default: return pin2;
        endcase
    endfunction

    function automatic logic get_busy(input int id);
        case (id)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic int nbits(input int id);
        return 1 + CFG_D[id] + PB + CFG_S[id];
    endfunction

    // Reference frame: bit i is the line level during bit period i
    function automatic logic [11:0] mk_frame(input int id, input logic [7:0] d);
        logic [11:0] f;
        logic        par;
        f    = '1;
        f[0] = 1'b0;
        par  = 1'b0;
        for (int i = 0; i < CFG_D[id]; i++) begin
            f[1+i] = d[i];
            par    = par ^ d[i];
        end
        if (PB == 1) f[1+CFG_D[id]] = par;
        return f;
    endfunction

    task automatic drive(input int id, input logic [7:0] d, input logic en);
        case (id)
            0: begin d0 = d;      en0 = en; end
            1: begin d1 = d;      en1 = en; end
            default: begin d2 = d[6:0]; en2 = en; end
        endcase
    endtask

    task automatic push(input int id, input logic [7:0] d);
        case (id)
            0: q0.push_back(d);
            1: q1.push_back(d);
            default: q2.push_back(d & 8'h7F);
        endcase
    endtask

    task automatic check_frame(input int id, input logic [11:0] fr);
        int          n;
        logic [11:0] msk;
        logic [7:0]  e;
        int          qs;
        n   = nbits(id);
        msk = (12'h1 << n) - 12'h1;
        qs  = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
        if (qs == 0) begin
            total++;
            bad++;
            $display("FAIL mon%0d_unexpected: frame %0h seen, expected none", id, fr & msk);
        end else begin
            case (id)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("mon%0d_frame", id), 32'(fr & msk), 32'(mk_frame(id, e) & msk));
        end
    endtask

    // Line monitor: samples each bit mid-period and scores decoded frames
    task automatic mon(input int id);
        int          b, n, c;
        bit          act;
        logic [11:0] fr;
        b   = CFG_B[id];
        n   = nbits(id);
        act = 1'b0;
        c   = 0;
        fr  = '1;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                act = 1'b0;
                continue;
            end
            if (!act) begin
                if (get_pin(id) == 1'b0) begin
                    act = 1'b1;
                    c   = 0;
                    fr  = '1;
                end
            end else begin
                c++;
            end
            if (act) begin
                if ((c % b) == (b / 2)) fr[c / b] = get_pin(id);
                if (c == n * b - 1) begin
                    act = 1'b0;
                    check_frame(id, fr);
                end
            end
        end
    endtask

    initial mon(0);
    initial mon(1);
    initial mon(2);

    // Cycle-exact frame check from an idle, empty transmitter
    task automatic send_frame(input vec_t v);
        int n, b;
        n = nbits(v.id);
        b = CFG_B[v.id];
        push(v.id, v.din);
        drive(v.id, v.din, 1'b1);
        step();
        drive(v.id, v.din, 1'b0);
        chk($sformatf("d%0d_lat_pin", v.id), get_pin(v.id), 1'b1);
        chk($sformatf("d%0d_lat_busy", v.id), get_busy(v.id), 1'b1);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < b; k++) begin
                step();
                chk($sformatf("d%0d_%0h_bit%0d", v.id, v.din, i), get_pin(v.id), v.exp[i]);
                chk($sformatf("d%0d_busy_bit%0d", v.id, i), get_busy(v.id), 1'b1);
            end
        end
        step();
        chk($sformatf("d%0d_end_pin", v.id), get_pin(v.id), 1'b1);
        chk($sformatf("d%0d_end_busy", v.id), get_busy(v.id), 1'b0);
    endtask

    vec_t tbl[7];

    initial begin
        int   t, c0, c1;
        vec_t v;

        tbl[0] = '{0, 8'h48, mk_frame(0, 8'h48)};
        tbl[1] = '{0, 8'h00, mk_frame(0, 8'h00)};
        tbl[2] = '{0, 8'hFF, mk_frame(0, 8'hFF)};
        tbl[3] = '{0, 8'hA5, mk_frame(0, 8'hA5)};
        tbl[4] = '{1, 8'h3C, mk_frame(1, 8'h3C)};
        tbl[5] = '{2, 8'h41, mk_frame(2, 8'h41)};
        tbl[6] = '{2, 8'h2A, mk_frame(2, 8'h2A)};

        rst = 1'b1;
        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        drive(2, 8'h00, 1'b0);
        repeat (3) step();
        chk("rst_pin0", pin0, 1'b1);   chk("rst_busy0", busy0, 1'b0);
        chk("rst_ovf0", ovf0, 1'b0);   chk("rst_full0", full0, 1'b0);
        chk("rst_pin1", pin1, 1'b1);   chk("rst_busy1", busy1, 1'b0);
        chk("rst_pin2", pin2, 1'b1);   chk("rst_busy2", busy2, 1'b0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) send_frame(tbl[i]);

        // Back-to-back "Hi": second start follows first stop with no gap
        push(0, 8'h48);
        push(0, 8'h69);
        drive(0, 8'h48, 1'b1);
        step();
        drive(0, 8'h69, 1'b1);
        step();
        drive(0, 8'h69, 1'b0);
        t = 0;
        while (pin0 !== 1'b0 && t < 10) begin step(); t++; end
        c0 = cyc;
        while (busy0 !== 1'b0 && t < 300) begin step(); t++; end
        c1 = cyc;
        chk("b2b_len", c1 - c0, 2 * nbits(0) * CFG_B[0]);

        // Overflow on the 4-deep FIFO: five bytes fit, the sixth is dropped
        for (int j = 0; j < 6; j++) begin
            if (j < 5) push(1, 8'h10 + 8'(j));
            drive(1, 8'h10 + 8'(j), 1'b1);
            step();
            if (j == 3) chk("ovf_full_pre", full1, 1'b0);
            if (j == 4) begin
                chk("ovf_full", full1, 1'b1);
                chk("ovf_not_yet", ovf1, 1'b0);
            end
            if (j == 5) chk("ovf_set", ovf1, 1'b1);
        end
        drive(1, 8'h00, 1'b0);
        t = 0;
        while (busy1 !== 1'b0 && t < 1000) begin step(); t++; end
        chk("ovf_drain_busy", busy1, 1'b0);
        chk("ovf_sticky", ovf1, 1'b1);
        chk("ovf_full_clr", full1, 1'b0);
        chk("ovf_q_empty", q1.size(), 0);

        // Reset during data bit 3 of 0xA5 with two more bytes queued
        push(0, 8'hA5);
        push(0, 8'h11);
        push(0, 8'h22);
        drive(0, 8'hA5, 1'b1);
        step();
        drive(0, 8'h11, 1'b1);
        step();
        drive(0, 8'h22, 1'b1);
        step();
        drive(0, 8'h00, 1'b0);
        repeat (11) step();
        chk("mid_bit3", pin0, 1'b0);
        chk("mid_busy", busy0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        q0.delete();
        chk("mid_rst_pin", pin0, 1'b1);
        chk("mid_rst_busy", busy0, 1'b0);
        chk("mid_rst_ovf", ovf0, 1'b0);
        chk("mid_rst_full", full0, 1'b0);
        repeat (4) step();
        chk("mid_flush_busy", busy0, 1'b0);
        chk("mid_flush_pin", pin0, 1'b1);
        v = '{0, 8'h01, mk_frame(0, 8'h01)};
        send_frame(v);

        repeat (5) step();
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
